sha256d_nonce_sweep: RTL and testbench



---
 rtl/sha256d_nonce_sweep.sv | 213 +++++++++++++++++++++
 tb/tb_sha256d_nonce_sweep.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256d_nonce_sweep.sv
// Double-SHA-256 tail engine: sweeps a nonce range, hashing block 2
// of the header and then the 256-bit intermediate digest, one round per cycle.
module sha256d_nonce_sweep #(
  parameter int          OUT_WORDS    = 1,
  parameter logic [31:0] NONCE_STRIDE = 32'd1,
  parameter bit          STOP_ON_HIT  = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [255:0]            h_in,
  input  logic [95:0]             in,
  input  logic [31:0]             nonce_base,
  input  logic [31:0]             nonce_count,
  input  logic [31:0]             target,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_nonce,
  output logic [OUT_WORDS*32-1:0] out_hash,
  output logic                    out_hit,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [2:0] {
    IDLE, LOAD, RND1, FIN1, RND2, FIN2, OUT
  } state_t;

  localparam logic [0:7][31:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [0:63][31:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ep0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] ep1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] sg0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sg1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  state_t state_q, state_d;
  logic done_q, done_d;

  logic [0:7][31:0]  hin_q;
  logic [0:2][31:0]  in_q;
  logic [31:0]       tgt_q;
  logic [31:0]       nonce_q;
  logic [31:0]       rem_q;
  logic [0:7][31:0]  hv_q;
  logic [0:15][31:0] w_q;
  logic [5:0]        rnd_q;

  logic [OUT_WORDS*32-1:0] hash_q;
  logic [31:0]             onon_q;
  logic                    hit_q;

  logic [31:0]       t1, t2, w_new;
  logic [0:7][31:0]  hv_rnd, hsum1, hsum2;
  logic [0:15][31:0] w_shift;
  logic              last;

  // w_q is a sliding 16-word window: w_q[0] is the current round's word.
  always_comb begin
    t1 = hv_q[7] + ep1(hv_q[4])
       + ((hv_q[4] & hv_q[5]) ^ (~hv_q[4] & hv_q[6]))
       + K[rnd_q] + w_q[0];
    t2 = ep0(hv_q[0])
       + ((hv_q[0] & hv_q[1]) ^ (hv_q[0] & hv_q[2])
          ^ (hv_q[1] & hv_q[2]));
    hv_rnd = {t1 + t2, hv_q[0], hv_q[1], hv_q[2],
              hv_q[3] + t1, hv_q[4], hv_q[5], hv_q[6]};
    w_new = sg1(w_q[14]) + w_q[9] + sg0(w_q[1]) + w_q[0];
    w_shift = '0;
    for (int j = 0; j < 15; j++) w_shift[j] = w_q[j+1];
    w_shift[15] = w_new;
    for (int j = 0; j < 8; j++) begin
      hsum1[j] = hin_q[j] + hv_q[j];
      hsum2[j] = IV[j] + hv_q[j];
    end
  end

  assign last = (rem_q == 32'd1) || (STOP_ON_HIT && hit_q);

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (nonce_count == 32'd0) done_d  = 1'b1;
          else                      state_d = LOAD;
        end
      end
      LOAD: state_d = RND1;
      RND1: if (rnd_q == 6'd63) state_d = FIN1;
      FIN1: state_d = RND2;
      RND2: if (rnd_q == 6'd63) state_d = FIN2;
      FIN2: state_d = OUT;
      OUT: begin
        if (out_ready) begin
          if (last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      hin_q   <= '0;
      in_q    <= '0;
      tgt_q   <= '0;
      nonce_q <= '0;
      rem_q   <= '0;
      hv_q    <= '0;
      w_q     <= '0;
      rnd_q   <= '0;
      hash_q  <= '0;
      onon_q  <= '0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            for (int j = 0; j < 8; j++) hin_q[j] <= h_in[32*j +: 32];
            for (int j = 0; j < 3; j++) in_q[j] <= in[32*j +: 32];
            tgt_q   <= target;
            nonce_q <= nonce_base;
            rem_q   <= nonce_count;
          end
        end
        LOAD: begin
          hv_q  <= hin_q;
          w_q   <= {in_q[0], in_q[1], in_q[2], nonce_q,
                    32'h8000_0000, 320'd0, 32'd640};
          rnd_q <= '0;
        end
        RND1, RND2: begin
          hv_q  <= hv_rnd;
          w_q   <= w_shift;
          rnd_q <= rnd_q + 6'd1;
        end
        FIN1: begin
          hv_q  <= IV;
          w_q   <= {hsum1, 32'h8000_0000, 192'd0, 32'd256};
          rnd_q <= '0;
        end
        FIN2: begin
          for (int j = 0; j < OUT_WORDS; j++)
            hash_q[32*j +: 32] <= hsum2[j];
          onon_q <= nonce_q;
          hit_q  <= hsum2[0] < tgt_q;
        end
        OUT: begin
          if (out_ready) begin
            rem_q   <= rem_q - 32'd1;
            nonce_q <= nonce_q + NONCE_STRIDE;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid = (state_q == OUT);
  assign out_nonce = onon_q;
  assign out_hash  = hash_q;
  assign out_hit   = hit_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_sha256d_nonce_sweep.sv
// Bench for sha256d_nonce_sweep: directed sweeps checked against a
// reference double-SHA-256 through a result scoreboard.
module tb_sha256d_nonce_sweep;

  localparam int          OW     = 8;
  localparam logic [31:0] STRIDE = 32'd4;
  localparam bit          STOP   = 1'b1;

  typedef logic [0:7][31:0]  w8_t;
  typedef logic [0:15][31:0] w16_t;
  typedef logic [0:2][31:0]  w3_t;

  typedef struct packed {
    logic [31:0]      nonce;
    logic [OW*32-1:0] hash;
    logic             hit;
  } res_t;

  localparam w8_t IVT = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [255:0]     h_in = '0;
  logic [95:0]      in_w = '0;
  logic [31:0]      nonce_base = '0;
  logic [31:0]      nonce_count = '0;
  logic [31:0]      target = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [31:0]      out_nonce;
  logic [OW*32-1:0] out_hash;
  logic             out_hit;
  logic             busy;
  logic             done;

  sha256d_nonce_sweep #(
    .OUT_WORDS(OW), .NONCE_STRIDE(STRIDE), .STOP_ON_HIT(STOP)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .h_in(h_in), .in(in_w),
    .nonce_base(nonce_base), .nonce_count(nonce_count),
    .target(target),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_nonce(out_nonce), .out_hash(out_hash),
    .out_hit(out_hit), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  res_t sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic w8_t compress(input w8_t st, input w16_t m);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, s0, s1, t1, t2;
    w8_t r;
    for (int t = 0; t < 16; t++) w[t] = m[t];
    for (int t = 16; t < 64; t++) begin
      s0 = rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = s1 + w[t-7] + s0 + w[t-16];
    end
    {a, b, c, d, e, f, g, h} = st;
    for (int t = 0; t < 64; t++) begin
      t1 = h + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25))
         + ((e & f) ^ (~e & g)) + KT[t] + w[t];
      t2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22))
         + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1;
      d = c; c = b; b = a; a = t1 + t2;
    end
    r = {a, b, c, d, e, f, g, h};
    for (int j = 0; j < 8; j++) r[j] = r[j] + st[j];
    return r;
  endfunction

  function automatic w8_t dsha(input w8_t mid, input w3_t m,
                               input logic [31:0] nonce);
    w8_t h1;
    h1 = compress(mid, {m[0], m[1], m[2], nonce,
                        32'h8000_0000, 320'd0, 32'd640});
    return compress(IVT, {h1, 32'h8000_0000, 192'd0, 32'd256});
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: scoreboard pops, latency, stability, done/valid exclusion.
  logic        pv = 1'b0;
  logic        pr = 1'b0;
  res_t        prev;
  int          ref_c = 0;
  int          hs_c = 0;
  int          done_c = 0;
  int          hs_cnt = 0;
  bit          done_seen = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      pv = 1'b0;
    end else begin
      if (start && !busy) ref_c = cyc;
      if (done || out_valid) chk("done_and_valid", done && out_valid, 0);
      if (out_valid && !pv) chk("valid_latency", cyc - ref_c, 132);
      if (out_valid && pv && !pr)
        chk("stall_stable", {out_nonce, out_hash, out_hit}, prev);
      if (out_valid && out_ready) begin
        hs_cnt++;
        hs_c  = cyc;
        ref_c = cyc;
        chk("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          res_t r;
          r = sb.pop_front();
          chk("out_nonce", out_nonce, r.nonce);
          chk("out_hash", out_hash, r.hash);
          chk("out_hit", out_hit, r.hit);
        end
      end
      if (done) begin
        done_seen = 1'b1;
        done_c    = cyc;
      end
      pv   = out_valid;
      pr   = out_ready;
      prev = {out_nonce, out_hash, out_hit};
    end
  end

  function automatic int push_sweep(input w8_t mid, input w3_t m,
                                    input logic [31:0] base,
                                    input logic [31:0] count,
                                    input logic [31:0] tgt);
    logic [31:0] nn;
    w8_t         d;
    res_t        r;
    int          n;
    nn = base;
    n  = 0;
    for (int i = 0; i < int'(count); i++) begin
      d = dsha(mid, m, nn);
      r.nonce = nn;
      for (int j = 0; j < OW; j++) r.hash[32*j +: 32] = d[j];
      r.hit = d[0] < tgt;
      sb.push_back(r);
      n++;
      if (STOP && r.hit) break;
      nn = nn + STRIDE;
    end
    return n;
  endfunction

  task automatic do_start(input w8_t mid, input w3_t m,
                          input logic [31:0] base,
                          input logic [31:0] count,
                          input logic [31:0] tgt);
    @(posedge clk); #1;
    for (int j = 0; j < 8; j++) h_in[32*j +: 32] = mid[j];
    for (int j = 0; j < 3; j++) in_w[32*j +: 32] = m[j];
    nonce_base  = base;
    nonce_count = count;
    target      = tgt;
    done_seen   = 1'b0;
    start       = 1'b1;
    @(posedge clk); #1;
    start       = 1'b0;
    h_in        = {8{$urandom}};
    in_w        = {3{$urandom}};
    nonce_base  = $urandom;
    nonce_count = $urandom;
    target      = $urandom;
  endtask

  task automatic wait_done(input int bound);
    for (int i = 0; i < bound && !done_seen; i++) begin
      @(negedge clk); #1;
    end
    chk("done_seen", done_seen, 1);
    chk("done_after_hs", done_c, hs_c + 1);
    chk("busy_after_done", busy, 0);
    chk("sb_drained", sb.size(), 0);
  endtask

  task automatic wait_valid(input int bound);
    for (int i = 0; i < bound && !out_valid; i++) begin
      @(negedge clk); #1;
    end
    chk("valid_seen", out_valid, 1);
  endtask

  function automatic w8_t rnd8();
    w8_t v;
    for (int j = 0; j < 8; j++) v[j] = $urandom;
    return v;
  endfunction

  function automatic w3_t rnd3();
    w3_t v;
    for (int j = 0; j < 3; j++) v[j] = $urandom;
    return v;
  endfunction

  initial begin
    w8_t mid;
    w3_t msg;
    int  h0, n;

    chk("model_abc",
        compress(IVT, {32'h6162_6380, 448'd0, 32'h18}),
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_outs",
        {out_valid, out_hit, busy, done, out_nonce, out_hash}, 0);

    // Single nonce
    mid = rnd8();
    msg = rnd3();
    n  = push_sweep(mid, msg, 32'h1234_5678, 1, 32'h8000_0000);
    h0 = hs_cnt;
    do_start(mid, msg, 32'h1234_5678, 1, 32'h8000_0000);
    wait_done(300);
    chk("single_hs", hs_cnt - h0, n);

    // Stride sweep, with a start pulse while busy that must be ignored
    mid = rnd8();
    msg = rnd3();
    n  = push_sweep(mid, msg, 32'h10, 3, 32'h0);
    h0 = hs_cnt;
    do_start(mid, msg, 32'h10, 3, 32'h0);
    repeat (50) @(posedge clk);
    #1 nonce_count = 0;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(600);
    chk("stride_hs", hs_cnt - h0, 3);

    // Backpressure
    mid = rnd8();
    msg = rnd3();
    n  = push_sweep(mid, msg, 32'h100, 2, 32'h0);
    h0 = hs_cnt;
    out_ready = 1'b0;
    do_start(mid, msg, 32'h100, 2, 32'h0);
    wait_valid(200);
    repeat (20) @(negedge clk);
    #1;
    chk("stall_no_hs", hs_cnt - h0, 0);
    chk("stall_valid", out_valid, 1);
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk); #1;
    chk("release_hs", hs_cnt - h0, 1);
    wait_done(300);
    chk("bp_hs", hs_cnt - h0, 2);

    // Hit with early stop
    mid = rnd8();
    msg = rnd3();
    n  = push_sweep(mid, msg, 32'h200, 5, 32'hFFFF_FFFF);
    h0 = hs_cnt;
    do_start(mid, msg, 32'h200, 5, 32'hFFFF_FFFF);
    wait_done(800);
    chk("hit_hs", hs_cnt - h0, n);

    // No hit: full sweep
    n  = push_sweep(mid, msg, 32'h200, 5, 32'h0);
    h0 = hs_cnt;
    do_start(mid, msg, 32'h200, 5, 32'h0);
    wait_done(800);
    chk("nohit_hs", hs_cnt - h0, 5);

    // count = 0
    h0 = hs_cnt;
    do_start(mid, msg, 32'h300, 0, 32'h0);
    repeat (4) @(negedge clk);
    #1;
    chk("cnt0_done", done_seen, 1);
    chk("cnt0_done_cyc", done_c, ref_c + 1);
    chk("cnt0_no_hs", hs_cnt - h0, 0);
    chk("cnt0_idle", {busy, out_valid}, 0);

    // Nonce wrap
    mid = rnd8();
    msg = rnd3();
    n  = push_sweep(mid, msg, 32'hFFFF_FFFC, 2, 32'h0);
    h0 = hs_cnt;
    do_start(mid, msg, 32'hFFFF_FFFC, 2, 32'h0);
    wait_done(400);
    chk("wrap_hs", hs_cnt - h0, 2);

    // Reset during RND2
    n = push_sweep(mid, msg, 32'h400, 1, 32'h0);
    do_start(mid, msg, 32'h400, 1, 32'h0);
    repeat (100) @(posedge clk);
    #1 reset = 1'b1;
    sb.delete();
    @(posedge clk); #1 reset = 1'b0;
    chk("rst_mid_outs",
        {out_valid, out_hit, busy, done, out_nonce, out_hash}, 0);
    done_seen = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    chk("rst_mid_no_done", done_seen, 0);

    mid = rnd8();
    msg = rnd3();
    n  = push_sweep(mid, msg, 32'h500, 1, 32'h0);
    h0 = hs_cnt;
    do_start(mid, msg, 32'h500, 1, 32'h0);
    wait_done(300);
    chk("after_rst_hs", hs_cnt - h0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
